// File: rtl/iiitb_4bbc.sv
// iiitb_4bbc: WIDTH-bit synchronous binary up/down counter.
// The count moves up or down by one on every rising edge and wraps modulo 2**WIDTH.
// The reset is synchronous and active-low.
// Count is driven directly by the state flop, so no input has a combinational path to it.

module iiitb_4bbc #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             UpOrDown,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step by one in the sampled direction; unsigned wrap comes for free.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
        count_d = count_q;
        if (UpOrDown) begin
            count_d = count_q + STEP;
        end else begin
            count_d = count_q - STEP;
        end
    end

    // Count register: synchronous active-low reset wins over the direction input.
    always_ff @(posedge Clk) begin
        // NOTE: reset is sampled only at the edge, so a low pulse between edges is ignored;
        // non-blocking assignment keeps the flop update race-free.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: tb/tb_iiitb_4bbc.sv
// tb_iiitb_4bbc: scoreboard bench for the up/down counter.
// The stimulus process drives inputs on falling edges and queues the value Count must hold after the next rising edge.
// The monitor samples Count shortly after each rising edge and compares it with the head of the queue.

module tb_iiitb_4bbc;

    localparam int WIDTH = 4;

    logic             Clk;
    logic             reset;
    logic             UpOrDown;
    logic [WIDTH-1:0] Count;

    logic [WIDTH-1:0] sb_q [$];
    int               n_checks;
    int               n_fail;

    // Hand-computed expected sequences.
    logic [WIDTH-1:0] up_wrap_exp [20] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                           4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [WIDTH-1:0] down_exp [3]     = '{4'd15, 4'd14, 4'd13};
    logic [WIDTH-1:0] turn_dn_exp [3]  = '{4'd6, 4'd5, 4'd4};
    logic [WIDTH-1:0] after_rst_exp[3] = '{4'd1, 4'd2, 4'd3};

    iiitb_4bbc #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .UpOrDown (UpOrDown),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle's inputs on the falling edge and queue the count expected after the next rising edge.
    task automatic step(input logic rst_v, input logic dir_v, input logic [WIDTH-1:0] exp_v);
        @(negedge Clk);
        reset    = rst_v;
        UpOrDown = dir_v;
        sb_q.push_back(exp_v);
    endtask

    // Same as step, but also pulse reset low briefly between edges; the pulse must be ignored.
    task automatic step_with_glitch(input logic dir_v, input logic [WIDTH-1:0] exp_v);
        step(1'b1, dir_v, exp_v);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    // Monitor: compare Count against the scoreboard shortly after each rising edge.
    initial begin
        logic [WIDTH-1:0] exp_v;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                n_checks++;
                if (Count !== exp_v) begin
                    n_fail++;
                    $display("FAIL count t=%0t got=%0d expected=%0d", $time, Count, exp_v);
                end
            end
        end
    end

    initial begin
        int budget;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        UpOrDown = 1'b0;

        // Reset held low for five edges while the direction toggles: the count stays at 0.
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 4'd0);

        // Count up for twenty edges, wrapping from 15 to 0.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, up_wrap_exp[i]);

        // Reset, then count down, wrapping from 0 to 15.
        step(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, down_exp[i]);

        // Count up to 7, then reverse: the next values are 6, 5, 4 with no skip and no repeat.
        step(1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, WIDTH'(i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, turn_dn_exp[i]);

        // Count up to 11, reset for one edge while counting up, then count up again from 0.
        step(1'b0, 1'b1, 4'd0);
        for (int i = 1; i <= 11; i++) step(1'b1, 1'b1, WIDTH'(i));
        step(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, after_rst_exp[i]);

        // Pulse reset low between edges only: the counter must keep counting (3 -> 4 -> 5 -> 4).
        step_with_glitch(1'b1, 4'd4);
        step_with_glitch(1'b1, 4'd5);
        step_with_glitch(1'b0, 4'd4);

        // Let the monitor drain the scoreboard, within a bounded number of cycles.
        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(negedge Clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
